// File: rtl/mod12_timer_arbiter_pkg.sv
// Shared types and default sizing for the modulo-12 timer arbiter slice.
// The FSM state encoding is fixed so that debug dumps read consistently across designs.
package mod12_timer_arbiter_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_MOD     = 12;
    localparam int DEF_CW      = 4;
    localparam int DEF_IDW     = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mod12_timer_arbiter_if.sv
// Requester-side bus of the timer arbiter.
// The requesters drive req/preset; the arbiter returns ownership, status and completion.
interface mod12_timer_arbiter_if
    import mod12_timer_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int CW      = DEF_CW,
    parameter int IDW     = DEF_IDW
);
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*CW-1:0] preset;
    logic [NUM_REQ-1:0]    grant;
    logic [IDW-1:0]        owner_id;
    logic                  busy;
    logic [CW-1:0]         count;
    logic [NUM_REQ-1:0]    done;

    modport master (
        output req, preset,
        input  grant, owner_id, busy, count, done
    );

    modport slave (
        input  req, preset,
        output grant, owner_id, busy, count, done
    );
endinterface

// File: rtl/mod12_timer_arbiter_mod_n_counter.sv
// Loadable modulo-MOD up-counter that saturates at MOD-1 instead of wrapping.
// Control priority is reset > clear > load > enable.
module mod_n_counter
    import mod12_timer_arbiter_pkg::*;
#(
    parameter int MOD = DEF_MOD,
    parameter int CW  = DEF_CW
)(
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          load,
    input  logic          enable,
    input  logic [CW-1:0] d_in,
    output logic [CW-1:0] d_out
);
    localparam logic [CW-1:0] TC = CW'(MOD - 1);

    always_ff @(posedge clock) begin
        if (reset) begin
            d_out <= '0;
        end else if (clear) begin
            d_out <= '0;
        end else if (load) begin
            d_out <= d_in;
        end else if (enable && (d_out != TC)) begin
            d_out <= d_out + 1'b1;
        end
    end
endmodule

// File: rtl/mod12_timer_arbiter.sv
// Round-robin arbiter sharing one modulo-MOD interval counter among NUM_REQ requesters.
// The winner's preset is loaded, counted to MOD-1 and answered with a one-cycle done pulse.
module mod12_timer_arbiter
    import mod12_timer_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int MOD     = DEF_MOD,
    parameter int CW      = DEF_CW,
    parameter int IDW     = DEF_IDW
)(
    input  logic                  clock,
    input  logic                  reset,
    mod12_timer_arbiter_if.slave  bus
);
    localparam logic [CW-1:0]  TC   = CW'(MOD - 1);
    localparam logic [IDW-1:0] LAST = IDW'(NUM_REQ - 1);

    state_t               state_reg, state_next;
    logic [NUM_REQ-1:0]   grant_reg, grant_next;
    logic [IDW-1:0]       owner_reg, owner_next;
    logic [IDW-1:0]       rr_ptr_reg, rr_ptr_next;
    logic [IDW-1:0]       winner, owner_inc;
    logic                 owner_req;
    logic                 cnt_clear, cnt_load, cnt_enable;
    logic [CW-1:0]        count_val, load_val;
    logic [CW-1:0]        preset_arr [NUM_REQ];

    // First requester at or after ptr, wrapping; only meaningful when |r.
    function automatic logic [IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDW-1:0]     ptr);
        logic [IDW-1:0] pick;
        logic [IDW-1:0] cand;
        logic           found;
        int             idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            cand = IDW'(idx);
            if (!found && r[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
        return pick;
    endfunction

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_preset
            assign preset_arr[gi] = bus.preset[gi*CW +: CW];
        end
    endgenerate

    // Out-of-range presets start at terminal count so the counter never exceeds MOD-1.
    assign load_val  = (preset_arr[owner_reg] > TC) ? TC : preset_arr[owner_reg];
    assign owner_inc = (owner_reg == LAST) ? '0 : owner_reg + 1'b1;
    assign owner_req = bus.req[owner_reg];
    assign winner    = rr_pick(bus.req, rr_ptr_reg);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            grant_reg  <= '0;
            owner_reg  <= '0;
            rr_ptr_reg <= '0;
        end else begin
            state_reg  <= state_next;
            grant_reg  <= grant_next;
            owner_reg  <= owner_next;
            rr_ptr_reg <= rr_ptr_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        grant_next  = grant_reg;
        owner_next  = owner_reg;
        rr_ptr_next = rr_ptr_reg;
        cnt_clear   = 1'b0;
        cnt_load    = 1'b0;
        cnt_enable  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                cnt_clear = 1'b1;
                if (|bus.req) begin
                    state_next = ST_LOAD;
                    owner_next = winner;
                    grant_next = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
                end
            end
            ST_LOAD, ST_RUN: begin
                if (!owner_req) begin
                    // Owner withdrew: release without a done pulse.
                    state_next  = ST_IDLE;
                    grant_next  = '0;
                    cnt_clear   = 1'b1;
                    rr_ptr_next = owner_inc;
                end else if (state_reg == ST_LOAD) begin
                    cnt_load   = 1'b1;
                    state_next = ST_RUN;
                end else if (count_val == TC) begin
                    state_next = ST_DONE;
                end else begin
                    cnt_enable = 1'b1;
                end
            end
            ST_DONE: begin
                state_next  = ST_IDLE;
                grant_next  = '0;
                cnt_clear   = 1'b1;
                rr_ptr_next = owner_inc;
            end
            default: begin
                state_next = ST_IDLE;
                grant_next = '0;
                cnt_clear  = 1'b1;
            end
        endcase
    end

    mod_n_counter #(
        .MOD (MOD),
        .CW  (CW)
    ) u_counter (
        .clock  (clock),
        .reset  (reset),
        .clear  (cnt_clear),
        .load   (cnt_load),
        .enable (cnt_enable),
        .d_in   (load_val),
        .d_out  (count_val)
    );

    assign bus.grant    = grant_reg;
    assign bus.owner_id = owner_reg;
    assign bus.busy     = (state_reg != ST_IDLE);
    assign bus.count    = count_val;
    assign bus.done     = (state_reg == ST_DONE) ? grant_reg : '0;
endmodule
